// File: rtl/uart_loader_pkg.sv
// Shared encodings for the UART command loader: FSM states and host opcodes.
// Host-side tooling mirrors the opcode values, so keep them stable.
package uart_loader_pkg;

   localparam logic [1:0] WAIT_CMD  = 2'd0;
   localparam logic [1:0] WAIT_ADDR = 2'd1;
   localparam logic [1:0] WAIT_LEN  = 2'd2;
   localparam logic [1:0] WAIT_DATA = 2'd3;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_RUN   = 8'h02;
   localparam logic [7:0] CMD_HALT  = 8'h03;

   function automatic logic is_opcode(input logic [7:0] op);
      return (op == CMD_WRITE) || (op == CMD_RUN) || (op == CMD_HALT);
   endfunction

endpackage

// File: rtl/uart_loader_timer.sv
// Inter-word idle timer: counts cycles while enabled, restarts on clear.
// expired is combinational and asserts on the cycle the count reaches TIMEOUT-1.
module uart_loader_timer #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !enable || expired) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_loader.sv
// UART program loader: decodes WRITE/RUN/HALT from received words and writes blocks into memory.
// Opcodes arrive as single bytes (one_byte=1 in WAIT_CMD); address, length and payload as full words.
module uart_cmd_loader
   import uart_loader_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       rx_word,
   input  logic              rx_valid,
   output logic              one_byte,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] addr_ptr_q,  addr_ptr_d;
   logic [31:0]       remaining_q, remaining_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_hold_q,  cpu_hold_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;
   logic              expired;
   logic [7:0]        opcode;

   assign opcode    = rx_word[7:0];
   assign one_byte  = (state_q == WAIT_CMD);
   assign busy      = (state_q != WAIT_CMD);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;
   assign err       = err_q;

   uart_loader_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (rx_valid),
      .enable  (busy),
      .expired (expired)
   );

   always_comb begin
      state_d     = state_q;
      addr_ptr_d  = addr_ptr_q;
      remaining_d = remaining_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      done_d      = 1'b0;
      err_d       = err_q;

      // A word arriving on the expiry cycle wins; the timeout is dropped.
      if (rx_valid) begin
         case (state_q)
            WAIT_CMD: begin
               err_d = !is_opcode(opcode);
               case (opcode)
                  CMD_WRITE: state_d = WAIT_ADDR;
                  CMD_RUN: begin
                     cpu_hold_d = 1'b0;
                     done_d     = 1'b1;
                  end
                  CMD_HALT: begin
                     cpu_hold_d = 1'b1;
                     done_d     = 1'b1;
                  end
                  default: ;
               endcase
            end
            WAIT_ADDR: begin
               addr_ptr_d = rx_word[ADDR_W-1:0];
               state_d    = WAIT_LEN;
            end
            WAIT_LEN: begin
               remaining_d = rx_word;
               if (rx_word == 32'd0) begin
                  done_d  = 1'b1;
                  state_d = WAIT_CMD;
               end else begin
                  state_d = WAIT_DATA;
               end
            end
            default: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_ptr_q;
               mem_wdata_d = rx_word;
               addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
               remaining_d = remaining_q - 32'd1;
               if (remaining_q == 32'd1) begin
                  done_d  = 1'b1;
                  state_d = WAIT_CMD;
               end
            end
         endcase
      end else if (expired) begin
         err_d   = 1'b1;
         state_d = WAIT_CMD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_CMD;
         addr_ptr_q  <= '0;
         remaining_q <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_ptr_q  <= addr_ptr_d;
         remaining_q <= remaining_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench for uart_cmd_loader with a short timeout.
module tb_uart_cmd_loader;

   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 40;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       rx_word;
   logic              rx_valid;
   logic              one_byte;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   int done_count = 0;
   int we_snap;
   int done_snap;

   uart_cmd_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_word   (rx_word),
      .rx_valid  (rx_valid),
      .one_byte  (one_byte),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) we_count++;
      if (done === 1'b1) done_count++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulses rx_valid for one cycle; returns on the negedge after the sampling edge.
   task automatic send(input logic [31:0] w);
      @(negedge clk);
      rx_word  = w;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_one_byte"}, {31'd0, one_byte}, 32'd1);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
      check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
      check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
      check({tag, "_wdata"},    mem_wdata,         32'd0);
      check({tag, "_busy"},     {31'd0, busy},     32'd0);
      check({tag, "_done"},     {31'd0, done},     32'd0);
      check({tag, "_err"},      {31'd0, err},      32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      rx_word  = 32'd0;
      rx_valid = 1'b0;
      idle(3);
      check_reset_values("rst");
      reset = 1'b0;
      idle(3);

      // HALT then RUN
      send(32'h0000_0003);
      check("halt_done", {31'd0, done}, 32'd1);
      check("halt_hold", {31'd0, cpu_hold}, 32'd1);
      idle(1);
      check("halt_done_pulse", {31'd0, done}, 32'd0);
      idle(8);
      send(32'h0000_0002);
      check("run_hold", {31'd0, cpu_hold}, 32'd0);
      check("run_done", {31'd0, done}, 32'd1);
      idle(9);

      // WRITE 0x10, len 3 (upper address bits ignored)
      send(32'h0000_0001);
      check("wr_one_byte", {31'd0, one_byte}, 32'd0);
      check("wr_busy", {31'd0, busy}, 32'd1);
      idle(9);
      send(32'hABCD_0010);
      check("wr_addr_one_byte", {31'd0, one_byte}, 32'd0);
      idle(9);
      send(32'd3);
      idle(9);
      send(32'hDEAD_BEEF);
      check("w0_we", {31'd0, mem_we}, 32'd1);
      check("w0_addr", {22'd0, mem_addr}, 32'h10);
      check("w0_data", mem_wdata, 32'hDEAD_BEEF);
      check("w0_done", {31'd0, done}, 32'd0);
      idle(1);
      check("w0_we_pulse", {31'd0, mem_we}, 32'd0);
      idle(8);
      send(32'h1234_5678);
      check("w1_addr", {22'd0, mem_addr}, 32'h11);
      check("w1_data", mem_wdata, 32'h1234_5678);
      check("w1_one_byte", {31'd0, one_byte}, 32'd0);
      idle(9);
      send(32'hCAFE_F00D);
      check("w2_we", {31'd0, mem_we}, 32'd1);
      check("w2_addr", {22'd0, mem_addr}, 32'h12);
      check("w2_data", mem_wdata, 32'hCAFE_F00D);
      check("w2_done", {31'd0, done}, 32'd1);
      check("w2_one_byte", {31'd0, one_byte}, 32'd1);
      check("w2_busy", {31'd0, busy}, 32'd0);
      idle(9);

      // Address wrap
      send(32'h0000_0001);
      idle(9);
      send(32'h0000_03FF);
      idle(9);
      send(32'd2);
      idle(9);
      send(32'h1111_1111);
      check("wrap0_addr", {22'd0, mem_addr}, 32'h3FF);
      check("wrap0_data", mem_wdata, 32'h1111_1111);
      idle(9);
      send(32'h2222_2222);
      check("wrap1_addr", {22'd0, mem_addr}, 32'h000);
      check("wrap1_data", mem_wdata, 32'h2222_2222);
      check("wrap1_done", {31'd0, done}, 32'd1);
      check("wrap_err", {31'd0, err}, 32'd0);
      idle(9);

      // Zero-length WRITE
      we_snap = we_count;
      send(32'h0000_0001);
      idle(9);
      send(32'h0000_0005);
      idle(9);
      send(32'd0);
      check("len0_done", {31'd0, done}, 32'd1);
      check("len0_one_byte", {31'd0, one_byte}, 32'd1);
      check("len0_busy", {31'd0, busy}, 32'd0);
      idle(9);
      check("len0_no_we", we_count, we_snap);

      // Bad opcode, then RUN clears err
      send(32'h0000_007F);
      check("bad_err", {31'd0, err}, 32'd1);
      check("bad_done", {31'd0, done}, 32'd0);
      check("bad_one_byte", {31'd0, one_byte}, 32'd1);
      idle(9);
      send(32'h0000_0002);
      check("clr_err", {31'd0, err}, 32'd0);
      check("clr_done", {31'd0, done}, 32'd1);
      idle(9);

      // Timeout after 2 of 4 data words
      we_snap   = we_count;
      done_snap = done_count;
      send(32'h0000_0001);
      idle(9);
      send(32'h0000_0020);
      idle(9);
      send(32'd4);
      idle(9);
      send(32'hAAAA_0001);
      idle(9);
      send(32'hAAAA_0002);
      check("to_busy_before", {31'd0, busy}, 32'd1);
      check("to_err_before", {31'd0, err}, 32'd0);
      idle(TIMEOUT + 20);
      check("to_writes", we_count - we_snap, 32'd2);
      check("to_no_done", done_count - done_snap, 32'd0);
      check("to_err", {31'd0, err}, 32'd1);
      check("to_one_byte", {31'd0, one_byte}, 32'd1);
      check("to_busy", {31'd0, busy}, 32'd0);
      idle(5);

      // Async reset mid WAIT_DATA, with a write pulse in flight
      send(32'h0000_0002);
      idle(9);
      send(32'h0000_0001);
      idle(9);
      send(32'h0000_0030);
      idle(9);
      send(32'd2);
      idle(9);
      send(32'h5555_AAAA);
      check("ar_we_before", {31'd0, mem_we}, 32'd1);
      check("ar_hold_before", {31'd0, cpu_hold}, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("arst");
      idle(2);
      reset = 1'b0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_loader.md
# uart_cmd_loader

Command/program loader sitting directly downstream of the 32-bit UART word receiver. Consumes received words (`data_out`/`data_end`) and drives that receiver's `one_byte` request so that command opcodes arrive as single bytes and payload arrives as full 32-bit words. Decodes a small command set that writes a block of words into instruction/data memory and holds or releases the CPU. Lets a host download a program over UART and start execution without JTAG.

## Interface
Parameters:
- `ADDR_W`, 10: memory word-address width.
- `TIMEOUT`, 1_000_000: idle clock cycles allowed between words inside a multi-word command before abort.

Ports:
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-high reset.
- `rx_word` input 32: received word (receiver `data_out`); byte 0 in [7:0] (little-endian).
- `rx_valid` input 1: one-cycle pulse, `rx_word` valid (receiver `data_end`).
- `one_byte` output 1: to receiver; 1 = next transfer is a single byte.
- `mem_we` output 1: one-cycle memory write strobe.
- `mem_addr` output ADDR_W: write word address.
- `mem_wdata` output 32: write data.
- `cpu_hold` output 1: 1 = CPU held in reset/stall.
- `busy` output 1: multi-word command in progress.
- `done` output 1: one-cycle pulse, command completed.
- `err` output 1: sticky error flag.

## Operation
- Opcodes, taken from `rx_word[7:0]`: 0x01 WRITE, 0x02 RUN, 0x03 HALT. Any other value sets `err` and stays in WAIT_CMD.
- States:
  - WAIT_CMD: `one_byte`=1. On `rx_valid`:
    - WRITE → WAIT_ADDR.
    - RUN → `cpu_hold`<=0, `done` pulse.
    - HALT → `cpu_hold`<=1, `done` pulse.
  - WAIT_ADDR: `one_byte`=0. On `rx_valid`, `addr_ptr`<=`rx_word[ADDR_W-1:0]` (upper bits ignored) → WAIT_LEN.
  - WAIT_LEN: on `rx_valid`, `remaining`<=`rx_word` (32 bit).
    - Count 0 → `done` pulse, return to WAIT_CMD.
    - Otherwise → WAIT_DATA.
  - WAIT_DATA: on `rx_valid`:
    - Register `mem_wdata`<=`rx_word`, `mem_addr`<=`addr_ptr`, `mem_we`<=1.
    - `addr_ptr`<=`addr_ptr`+1, wrapping modulo 2^ADDR_W.
    - `remaining`<=`remaining`-1.
    - If `remaining`==1, return to WAIT_CMD and pulse `done` in the same cycle as the final `mem_we`.
- `one_byte` is combinational from state: 1 only in WAIT_CMD. It is updated one cycle after `rx_valid`, well before the receiver's first-byte decision for the next word.
- `busy` = state is WAIT_ADDR, WAIT_LEN or WAIT_DATA.
- `err` is set by a bad opcode or a timeout. It clears on the next valid opcode accepted in WAIT_CMD.
- Timeout:
  - The counter resets on every `rx_valid` and runs only while `busy`.
  - On reaching TIMEOUT-1: `err`<=1, go to WAIT_CMD, no `done`. Memory writes already issued stand.
- `cpu_hold` is not changed by WRITE. The host issues HALT first if required.

## Timing
- Reset values: WAIT_CMD, `one_byte`=1, `cpu_hold`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, counters 0.
- All outputs except `one_byte` and `busy` are registered.
- Latency: `rx_valid` at cycle N → `mem_we`/`done`/`cpu_hold` change at N+1.
- `rx_valid` pulses are at least 10 cycles apart (receiver framing). A pulse on consecutive cycles is not required to be handled.
- `rx_valid` in the same cycle as a timeout expiry: the word is accepted and the timeout is ignored.
- `reset` asserted mid-command: immediate abort to reset values. Any `mem_we` pulse in flight is cut.
- `addr_ptr` wrap from 2^ADDR_W-1 to 0 is silent and does not raise `err`.

## Structure
- Shared package `uart_loader_pkg`: state encoding localparams (WAIT_CMD, WAIT_ADDR, WAIT_LEN, WAIT_DATA) and opcode constants (CMD_WRITE, CMD_RUN, CMD_HALT). The host-side tooling mirrors the opcodes.
- One sub-module, `uart_loader_timer`:
  - Parameterised by TIMEOUT; inputs `clear`, `enable`; output `expired`.
  - Counter width $clog2(TIMEOUT).
- The top level holds the FSM, `addr_ptr`, `remaining` and output registers.

## Test plan
- Reset, then HALT (0x03): `done` pulse, `cpu_hold` stays 1; RUN (0x02): `cpu_hold`=0 one cycle after `rx_valid`.
- WRITE, addr 0x10, len 3, data 0xDEADBEEF/0x12345678/0xCAFEF00D: three `mem_we` pulses at 0x10/0x11/0x12 with matching data; `done` with the third; `one_byte` 0 from the addr word until the last, then 1.
- WRITE, addr 2^ADDR_W-1, len 2: writes at 0x3FF then 0x000; `err` stays 0.
- WRITE, len 0: `done` pulse, no `mem_we`, back to WAIT_CMD. Opcode 0x7F: `err`=1; a following RUN clears `err`.
- WRITE, addr, len 4, then only 2 data words and silence for TIMEOUT cycles: exactly 2 writes, `err`=1, no `done`, `one_byte`=1. Async `reset` during WAIT_DATA: all outputs at reset values without a clock edge.
